dram_arbiter: RTL and testbench

// Upstream client arbiter for the cache-line DRAM controller (dram). Accepts whole-line requests from one

---
 rtl/dram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dram_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin arbiter serialising one write and two read clients onto dram
// Whole-line requests are held per client and issued one at a time; read lines return as a one-cycle pulse.
module dram_arbiter #(
    parameter int DRAM_ADDR_BITS  = 27,
    parameter int LINE_BITS       = 512,
    parameter int LINE_ALIGN_BITS = 6
) (
    input  logic                      sclk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [DRAM_ADDR_BITS-1:0] wr_addr,
    input  logic [LINE_BITS-1:0]      wr_data,
    input  logic [1:0]                rd_valid,
    output logic [1:0]                rd_ready,
    input  logic [DRAM_ADDR_BITS-1:0] rd_addr0,
    input  logic [DRAM_ADDR_BITS-1:0] rd_addr1,
    output logic [1:0]                rd_resp_valid,
    output logic [LINE_BITS-1:0]      rd_resp_data,
    input  logic                      dram_read_ready,
    input  logic                      dram_write_ready,
    output logic                      dram_read_request,
    output logic [DRAM_ADDR_BITS-1:0] dram_read_address,
    input  logic                      dram_read_response,
    input  logic [LINE_BITS-1:0]      dram_read_data,
    output logic                      dram_write_request,
    output logic [DRAM_ADDR_BITS-1:0] dram_write_address,
    output logic [LINE_BITS-1:0]      dram_write_data
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_W,
        WAIT_R
    } state_t;

    localparam logic [DRAM_ADDR_BITS-1:0] ALIGN_MASK = {DRAM_ADDR_BITS{1'b1}} << LINE_ALIGN_BITS;

    state_t                    state;
    logic [2:0]                pend;
    logic [1:0]                rr;
    logic [1:0]                g;
    logic [DRAM_ADDR_BITS-1:0] addr_w;
    logic [DRAM_ADDR_BITS-1:0] addr_r0;
    logic [DRAM_ADDR_BITS-1:0] addr_r1;
    logic [LINE_BITS-1:0]      data_w;

    logic [2:0]                accept;
    logic [2:0]                clr;
    logic [1:0]                rr_1;
    logic [1:0]                rr_2;
    logic [1:0]                pick;
    logic                      granted;

    function automatic logic [1:0] rr_next(input logic [1:0] id);
        return (id == 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

    // Client ids: 0 = write, 1 = R0, 2 = R1; pend bit index equals client id.
    assign accept   = {rd_valid[1] & ~pend[2], rd_valid[0] & ~pend[1], wr_valid & ~pend[0]};
    assign wr_ready = ~pend[0];
    assign rd_ready = ~pend[2:1];

    assign rr_1 = rr_next(rr);
    assign rr_2 = rr_next(rr_1);

    always_comb begin
        pick = rr_2;
        if (pend[rr_1]) begin
            pick = rr_1;
        end
        if (pend[rr]) begin
            pick = rr;
        end
    end

    always_comb begin
        clr = 3'b000;
        if ((state == WAIT_W && dram_write_ready) || (state == WAIT_R && dram_read_response)) begin
            clr = 3'b001 << g;
        end
    end

    // dram re-reads address/data every burst, so they follow the granted holding reg until back in IDLE.
    assign granted            = (state != IDLE);
    assign dram_write_address = (granted && g == 2'd0) ? addr_w : '0;
    assign dram_write_data    = (granted && g == 2'd0) ? data_w : '0;
    assign dram_read_address  = (granted && g == 2'd1) ? addr_r0 :
                                (granted && g == 2'd2) ? addr_r1 : '0;

    always_ff @(posedge sclk) begin
        if (rst) begin
            state              <= IDLE;
            pend               <= 3'b000;
            rr                 <= 2'd0;
            g                  <= 2'd0;
            addr_w             <= '0;
            addr_r0            <= '0;
            addr_r1            <= '0;
            data_w             <= '0;
            rd_resp_valid      <= 2'b00;
            rd_resp_data       <= '0;
            dram_read_request  <= 1'b0;
            dram_write_request <= 1'b0;
        end else begin
            pend <= (pend | accept) & ~clr;

            if (accept[0]) begin
                addr_w <= wr_addr & ALIGN_MASK;
                data_w <= wr_data;
            end
            if (accept[1]) begin
                addr_r0 <= rd_addr0 & ALIGN_MASK;
            end
            if (accept[2]) begin
                addr_r1 <= rd_addr1 & ALIGN_MASK;
            end

            dram_read_request  <= 1'b0;
            dram_write_request <= 1'b0;
            rd_resp_valid      <= 2'b00;

            case (state)
                IDLE: begin
                    if (pend != 3'b000 && dram_read_ready) begin
                        g     <= pick;
                        rr    <= rr_next(pick);
                        state <= ISSUE;
                        if (pick == 2'd0) begin
                            dram_write_request <= 1'b1;
                        end else begin
                            dram_read_request <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= (g == 2'd0) ? WAIT_W : WAIT_R;
                end
                WAIT_W: begin
                    if (dram_write_ready) begin
                        state <= IDLE;
                    end
                end
                WAIT_R: begin
                    // Only sampled here, so a response still high from the previous read is never seen.
                    if (dram_read_response) begin
                        rd_resp_data  <= dram_read_data;
                        rd_resp_valid <= (g == 2'd2) ? 2'b10 : 2'b01;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - self-checking bench for dram_arbiter with a behavioural dram model
// Vector table for single requests, hand-written sequences for arbitration, stale response and reset.
module tb_dram_arbiter;

    localparam int AW = 27;
    localparam int LW = 512;

    logic          sclk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [LW-1:0] wr_data;
    logic [1:0]    rd_valid;
    logic [1:0]    rd_ready;
    logic [AW-1:0] rd_addr0;
    logic [AW-1:0] rd_addr1;
    logic [1:0]    rd_resp_valid;
    logic [LW-1:0] rd_resp_data;
    logic          dram_ready;
    logic          dram_read_request;
    logic [AW-1:0] dram_read_address;
    logic          dram_resp;
    logic [LW-1:0] dram_rdata;
    logic          dram_write_request;
    logic [AW-1:0] dram_write_address;
    logic [LW-1:0] dram_write_data;

    always #5 sclk = ~sclk;

    dram_arbiter #(
        .DRAM_ADDR_BITS (AW),
        .LINE_BITS      (LW),
        .LINE_ALIGN_BITS(6)
    ) dut (
        .sclk              (sclk),
        .rst               (rst),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .rd_valid          (rd_valid),
        .rd_ready          (rd_ready),
        .rd_addr0          (rd_addr0),
        .rd_addr1          (rd_addr1),
        .rd_resp_valid     (rd_resp_valid),
        .rd_resp_data      (rd_resp_data),
        .dram_read_ready   (dram_ready),
        .dram_write_ready  (dram_ready),
        .dram_read_request (dram_read_request),
        .dram_read_address (dram_read_address),
        .dram_read_response(dram_resp),
        .dram_read_data    (dram_rdata),
        .dram_write_request(dram_write_request),
        .dram_write_address(dram_write_address),
        .dram_write_data   (dram_write_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %s", name, what);
    endtask

    function automatic logic [LW-1:0] data_for(input logic [AW-1:0] a);
        logic [31:0] w;
        w = 32'h1234_0000 ^ {5'b0, a};
        return {16{w}};
    endfunction

    // dram model: one transaction at a time, ready drops on request and recovers after the response.
    int            lat = 1;
    int            resp_hold = 1;
    int            ready_delay = 0;
    int            ph;
    int            cnt;
    int            rl;
    int            dl;
    logic          m_is_rd;
    logic [AW-1:0] m_addr;

    always @(posedge sclk) begin
        if (rst) begin
            dram_ready <= 1'b1;
            dram_resp  <= 1'b0;
            dram_rdata <= '0;
            ph         <= 0;
            cnt        <= 0;
            rl         <= 0;
            dl         <= 0;
            m_is_rd    <= 1'b0;
            m_addr     <= '0;
        end else begin
            case (ph)
                0: if (dram_read_request || dram_write_request) begin
                    dram_ready <= 1'b0;
                    m_is_rd    <= dram_read_request;
                    m_addr     <= dram_read_request ? dram_read_address : dram_write_address;
                    cnt        <= lat;
                    ph         <= 1;
                end
                1: if (cnt == 0) begin
                    if (m_is_rd) begin
                        dram_resp  <= 1'b1;
                        dram_rdata <= data_for(m_addr);
                        rl         <= resp_hold - 1;
                        dl         <= ready_delay;
                        ph         <= 2;
                    end else begin
                        dram_ready <= 1'b1;
                        ph         <= 0;
                    end
                end else begin
                    cnt <= cnt - 1;
                end
                default: begin
                    if (rl == 0) begin
                        dram_resp  <= 1'b0;
                        dram_rdata <= '0;
                    end else begin
                        rl <= rl - 1;
                    end
                    if (dl == 0) dram_ready <= 1'b1;
                    else dl <= dl - 1;
                    if (rl == 0 && dl == 0) ph <= 0;
                end
            endcase
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } wexp_t;

    wexp_t         wq[$];
    logic [LW-1:0] rq0[$];
    logic [LW-1:0] rq1[$];
    int            grant_log[$];
    int            pulses0 = 0;
    int            pulses1 = 0;
    int            rd_reqs = 0;
    int            wr_reqs = 0;
    int            exp_p0 = 0;
    int            exp_p1 = 0;
    int            exp_w = 0;
    wexp_t         mon_w;

    always @(negedge sclk) begin
        if (dram_read_request === 1'b1) begin
            rd_reqs++;
            chk("rd_req_while_ready", dram_ready, 1'b1);
        end
        if (dram_write_request === 1'b1) begin
            wr_reqs++;
            grant_log.push_back(0);
            chk("wr_req_while_ready", dram_ready, 1'b1);
            if (wq.size() == 0) begin
                fail_now("wr_unexpected", "write request, want none");
            end else begin
                mon_w = wq.pop_front();
                chk("wr_addr", dram_write_address, mon_w.addr);
                chk_line("wr_data", dram_write_data, mon_w.data);
            end
        end
        if (rd_resp_valid === 2'b01) begin
            pulses0++;
            grant_log.push_back(1);
            chk("ready_at_pulse0", rd_ready[0], 1'b1);
            if (rq0.size() == 0) fail_now("rd0_unexpected", "pulse for R0, want none");
            else chk_line("rd_data0", rd_resp_data, rq0.pop_front());
        end else if (rd_resp_valid === 2'b10) begin
            pulses1++;
            grant_log.push_back(2);
            chk("ready_at_pulse1", rd_ready[1], 1'b1);
            if (rq1.size() == 0) fail_now("rd1_unexpected", "pulse for R1, want none");
            else chk_line("rd_data1", rd_resp_data, rq1.pop_front());
        end else if (rd_resp_valid === 2'b11) begin
            fail_now("rd_pulse_onehot", "2'b11");
        end
    end

    typedef struct {
        int            client;
        logic [AW-1:0] addr;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] data;
        int            lat;
    } vec_t;

    vec_t vecs[7];

    function automatic logic ready_of(input int c);
        return (c == 0) ? wr_ready : rd_ready[c-1];
    endfunction

    function automatic logic req_of(input int c);
        return (c == 0) ? dram_write_request : dram_read_request;
    endfunction

    function automatic logic all_idle();
        return wr_ready && rd_ready == 2'b11 && ph == 0 && !dram_resp;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (!all_idle() && k < budget) begin
            @(negedge sclk);
            k++;
        end
        if (k >= budget) fail_now(name, "timeout waiting for idle");
        repeat (2) @(negedge sclk);
    endtask

    task automatic push_req(input int c, input logic [AW-1:0] a, input logic [AW-1:0] ea, input logic [LW-1:0] d);
        wexp_t e;
        if (c == 0) begin
            wr_valid = 1'b1;
            wr_addr  = a;
            wr_data  = d;
            e.addr   = ea;
            e.data   = d;
            wq.push_back(e);
            exp_w++;
        end else if (c == 1) begin
            rd_valid[0] = 1'b1;
            rd_addr0    = a;
            rq0.push_back(data_for(ea));
            exp_p0++;
        end else begin
            rd_valid[1] = 1'b1;
            rd_addr1    = a;
            rq1.push_back(data_for(ea));
            exp_p1++;
        end
    endtask

    task automatic check_counts();
        chk("pulses_r0", pulses0, exp_p0);
        chk("pulses_r1", pulses1, exp_p1);
        chk("write_reqs", wr_reqs, exp_w);
    endtask

    task automatic run_single(input vec_t v);
        lat = v.lat;
        chk("pre_ready", ready_of(v.client), 1'b1);
        push_req(v.client, v.addr, v.exp_addr, v.data);
        @(negedge sclk);
        wr_valid = 1'b0;
        rd_valid = 2'b00;
        chk("ready_drop", ready_of(v.client), 1'b0);
        chk("req_grant_cycle", req_of(v.client), 1'b0);
        @(negedge sclk);
        chk("req_issue_cycle", req_of(v.client), 1'b1);
        @(negedge sclk);
        chk("req_one_cycle", req_of(v.client), 1'b0);
        wait_idle("single_done", 200);
        check_counts();
        chk("idle_rd_addr", dram_read_address, 0);
        chk("idle_wr_addr", dram_write_address, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge sclk);
        rst = 1'b0;
        grant_log.delete();
    endtask

    task automatic check_order(input string name, input int exp_order[4]);
        chk({name, "_len"}, grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            for (int k = 0; k < 4; k++) chk(name, grant_log[k], exp_order[k]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int   order_a[4];
        int   order_b[4];
        int   k;
        int   r1_left;
        int   base_reqs;
        logic reissued;
        logic r0_sent;
        vec_t v;

        vecs[0] = '{0, 27'h0000045, 27'h0000040, {64{8'hA5}}, 1};
        vecs[1] = '{1, 27'h0001000, 27'h0001000, '0, 1};
        vecs[2] = '{2, 27'h7FFFFFF, 27'h7FFFFC0, '0, 0};
        vecs[3] = '{0, 27'h000003F, 27'h0000000, {16{32'hC0DE_0003}}, 0};
        vecs[4] = '{1, 27'h0000041, 27'h0000040, '0, 3};
        vecs[5] = '{2, 27'h1234567, 27'h1234540, '0, 2};
        vecs[6] = '{0, 27'h7FFFFFF, 27'h7FFFFC0, {16{32'hFEED_0006}}, 4};
        order_a = '{0, 1, 2, 0};
        order_b = '{2, 1, 2, 2};

        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_valid = 2'b00;
        rd_addr0 = '0;
        rd_addr1 = '0;
        repeat (2) @(negedge sclk);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_rd_ready", rd_ready, 2'b11);
        chk("rst_resp_valid", rd_resp_valid, 2'b00);
        chk("rst_rd_req", dram_read_request, 1'b0);
        chk("rst_wr_req", dram_write_request, 1'b0);
        chk("rst_rd_addr", dram_read_address, 0);
        chk("rst_wr_addr", dram_write_address, 0);
        chk_line("rst_resp_data", rd_resp_data, '0);
        chk_line("rst_wr_data", dram_write_data, '0);
        rst = 1'b0;
        @(negedge sclk);

        for (int i = 0; i < 7; i++) run_single(vecs[i]);

        // All three clients at once after reset; W re-requests as soon as its ready returns.
        do_reset();
        lat = 1;
        push_req(0, 27'h0000100, 27'h0000100, {16{32'hAAAA_0001}});
        push_req(1, 27'h0000200, 27'h0000200, '0);
        push_req(2, 27'h0000300, 27'h0000300, '0);
        @(negedge sclk);
        wr_valid = 1'b0;
        rd_valid = 2'b00;
        reissued = 1'b0;
        k = 0;
        while (!(reissued && !wr_valid && all_idle()) && k < 300) begin
            @(negedge sclk);
            k++;
            if (wr_valid) wr_valid = 1'b0;
            else if (!reissued && wr_ready) begin
                push_req(0, 27'h0000455, 27'h0000440, {16{32'hBBBB_0002}});
                reissued = 1'b1;
            end
        end
        if (k >= 300) fail_now("rr_all_timeout", "timeout");
        repeat (2) @(negedge sclk);
        check_order("rr_order", order_a);
        check_counts();

        // R1 streams three requests back to back while R0 posts one during the first R1 read.
        do_reset();
        push_req(2, 27'h0010000, 27'h0010000, '0);
        r1_left = 2;
        r0_sent = 1'b0;
        k = 0;
        while (k < 400) begin
            @(negedge sclk);
            k++;
            rd_valid = 2'b00;
            if (!r0_sent && dram_read_request) begin
                push_req(1, 27'h0020010, 27'h0020000, '0);
                r0_sent = 1'b1;
            end
            if (r1_left > 0 && rd_ready[1]) begin
                push_req(2, 27'h0010000 + 27'(r1_left * 64), 27'h0010000 + 27'(r1_left * 64), '0);
                r1_left--;
            end
            if (r1_left == 0 && r0_sent && rd_valid == 2'b00 && all_idle()) break;
        end
        if (k >= 400) fail_now("r1_stream_timeout", "timeout");
        repeat (2) @(negedge sclk);
        check_order("alt_order", order_b);
        check_counts();

        // Response held two cycles and ready slow to return: one pulse per read, no early grant.
        lat         = 2;
        resp_hold   = 2;
        ready_delay = 3;
        base_reqs   = rd_reqs;
        push_req(1, 27'h0030000, 27'h0030000, '0);
        push_req(2, 27'h0031040, 27'h0031040, '0);
        @(negedge sclk);
        rd_valid = 2'b00;
        wait_idle("stale_done", 300);
        chk("stale_rd_reqs", rd_reqs - base_reqs, 2);
        check_counts();
        lat         = 1;
        resp_hold   = 1;
        ready_delay = 0;

        // Reset while waiting for read data: the read is dropped without a pulse.
        lat = 6;
        rd_valid[0] = 1'b1;
        rd_addr0    = 27'h0040000;
        @(negedge sclk);
        rd_valid = 2'b00;
        @(negedge sclk);
        chk("rst_mid_issue", dram_read_request, 1'b1);
        @(negedge sclk);
        rst = 1'b1;
        @(negedge sclk);
        chk("mid_rst_rd_ready", rd_ready, 2'b11);
        chk("mid_rst_wr_ready", wr_ready, 1'b1);
        chk("mid_rst_resp_valid", rd_resp_valid, 2'b00);
        chk("mid_rst_rd_addr", dram_read_address, 0);
        rst = 1'b0;
        repeat (12) @(negedge sclk);
        check_counts();
        v = '{1, 27'h0002080, 27'h0002080, '0, 1};
        run_single(v);

        chk("wq_empty", wq.size(), 0);
        chk("rq0_empty", rq0.size(), 0);
        chk("rq1_empty", rq1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
